prog_loader: RTL

- Self-checking program loader and run supervisor for the multicycle RISC datapath.
- Streams (address, data) words into the datapath memory through the memory test-port: select, write-enable, address and data.
- Holds the CPU in reset for a programmable number of cycles, then releases it.
- Counts run cycles until the controller asserts done, or flags a timeout. This replaces hand-written memory-write and reset sequences with a reusable, synthesizable block.

---
 rtl/prog_loader.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// Program loader and run supervisor: streams (addr, data) words into the datapath
// memory test-port, holds the CPU in reset, then supervises the run until done or timeout.
module prog_loader #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int RST_CYCLES = 3,
    parameter int CNT_W      = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  max_cycles_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [ADDR_W-1:0] in_addr_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_last_i,
    input  logic              mem_grant_i,
    output logic              tb_sel_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              cpu_rst_o,
    input  logic              cpu_done_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              timeout_o,
    output logic [CNT_W-1:0]  cycle_count_o,
    output logic [ADDR_W:0]   words_loaded_o,
    output logic [DATA_W-1:0] checksum_o
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int HOLD_W = $clog2(RST_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_HOLD    = 3'd2,
        S_RUN     = 3'd3,
        S_DONE    = 3'd4,
        S_TIMEOUT = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic                tb_sel_q, tb_sel_d, cpu_rst_q, cpu_rst_d;
    logic                busy_q, busy_d, done_q, done_d, timeout_q, timeout_d;
    logic [ADDR_W-1:0]   fifo_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0]   fifo_data_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]      count_q, count_d;
    logic                last_seen_q, last_seen_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [CNT_W-1:0]    cycle_q, cycle_d, max_q, max_d;
    logic [ADDR_W:0]     words_q, words_d;
    logic [DATA_W-1:0]   checksum_q, checksum_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                fifo_full_s, fifo_empty_s, in_ready_s, push_s, pop_s, start_s;

    // Handshake and FIFO status decode; full is taken from registered occupancy only.
    always_comb begin
        fifo_full_s  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
        fifo_empty_s = (count_q == '0);
        in_ready_s   = (state_q == S_LOAD) && !fifo_full_s && !last_seen_q;
        push_s       = in_valid_i && in_ready_s;
        pop_s        = (state_q == S_LOAD) && !fifo_empty_s && mem_grant_i;
        start_s      = start_i && (state_q inside {S_IDLE, S_DONE, S_TIMEOUT});
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start_s) state_d = S_LOAD; else state_d = S_IDLE;
            S_LOAD:    if (last_seen_q && fifo_empty_s && !mem_we_q) state_d = S_HOLD;
                       else state_d = S_LOAD;
            S_HOLD:    if (hold_q == '0) state_d = S_RUN; else state_d = S_HOLD;
            S_RUN: begin
                if (cpu_done_i) state_d = S_DONE;
                else if ((max_q != '0) && ((cycle_q + CNT_W'(1)) == max_q)) state_d = S_TIMEOUT;
                else state_d = S_RUN;
            end
            S_DONE, S_TIMEOUT: if (start_s) state_d = S_LOAD; else state_d = state_q;
            default:   state_d = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the next state so they are registered with it.
    always_comb begin
        tb_sel_d  = 1'b1;
        cpu_rst_d = 1'b1;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        timeout_d = 1'b0;
        case (state_d)
            S_IDLE:    begin tb_sel_d = 1'b1; cpu_rst_d = 1'b1; end
            S_LOAD:    begin tb_sel_d = 1'b1; cpu_rst_d = 1'b1; busy_d = 1'b1; end
            S_HOLD:    begin tb_sel_d = 1'b0; cpu_rst_d = 1'b1; busy_d = 1'b1; end
            S_RUN:     begin tb_sel_d = 1'b0; cpu_rst_d = 1'b0; busy_d = 1'b1; end
            S_DONE:    begin tb_sel_d = 1'b0; cpu_rst_d = 1'b0; done_d = 1'b1; end
            S_TIMEOUT: begin tb_sel_d = 1'b0; cpu_rst_d = 1'b1; timeout_d = 1'b1; end
            default:   begin tb_sel_d = 1'b1; cpu_rst_d = 1'b1; end
        endcase
    end

    // Datapath next-state: FIFO pointers, write port, counters and checksum.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        last_seen_d = last_seen_q;
        mem_we_d    = pop_s;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        words_d     = words_q;
        checksum_d  = checksum_q;
        cycle_d     = cycle_q;
        max_d       = max_q;
        hold_d      = hold_q;
        if (push_s) wr_ptr_d = wr_ptr_q + PTR_W'(1); else wr_ptr_d = wr_ptr_q;
        if (pop_s) begin
            rd_ptr_d    = rd_ptr_q + PTR_W'(1);
            mem_addr_d  = fifo_addr_q[rd_ptr_q];
            mem_wdata_d = fifo_data_q[rd_ptr_q];
        end else begin
            rd_ptr_d    = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
        if (start_s) begin
            last_seen_d = 1'b0;
            words_d     = '0;
            checksum_d  = '0;
            cycle_d     = '0;
            max_d       = max_cycles_i;
        end else begin
            if (push_s && in_last_i) last_seen_d = 1'b1; else last_seen_d = last_seen_q;
            if (pop_s) begin
                if (words_q != '1) words_d = words_q + (ADDR_W+1)'(1); else words_d = words_q;
                checksum_d = checksum_q + fifo_data_q[rd_ptr_q];
            end else begin
                checksum_d = checksum_q;
            end
            if ((state_q == S_RUN) && !cpu_done_i) cycle_d = cycle_q + CNT_W'(1);
            else cycle_d = cycle_q;
        end
        if ((state_q == S_LOAD) && (state_d == S_HOLD)) hold_d = HOLD_W'(RST_CYCLES - 1);
        else if ((state_q == S_HOLD) && (hold_q != '0)) hold_d = hold_q - HOLD_W'(1);
        else hold_d = hold_q;
    end

    // FIFO storage; validity is tracked by the occupancy count, so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            fifo_addr_q[wr_ptr_q] <= in_addr_i;
            fifo_data_q[wr_ptr_q] <= in_data_i;
        end
    end

    // State, output and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            tb_sel_q    <= 1'b1;
            cpu_rst_q   <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            last_seen_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            words_q     <= '0;
            checksum_q  <= '0;
            cycle_q     <= '0;
            max_q       <= '0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            tb_sel_q    <= tb_sel_d;
            cpu_rst_q   <= cpu_rst_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            last_seen_q <= last_seen_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            words_q     <= words_d;
            checksum_q  <= checksum_d;
            cycle_q     <= cycle_d;
            max_q       <= max_d;
            hold_q      <= hold_d;
        end
    end

    assign in_ready_o     = in_ready_s;
    assign tb_sel_o       = tb_sel_q;
    assign cpu_rst_o      = cpu_rst_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign timeout_o      = timeout_q;
    assign mem_we_o       = mem_we_q;
    assign mem_addr_o     = mem_addr_q;
    assign mem_wdata_o    = mem_wdata_q;
    assign cycle_count_o  = cycle_q;
    assign words_loaded_o = words_q;
    assign checksum_o     = checksum_q;
endmodule
